// File: rtl/axis_skid_fifo.sv
// axis_skid_fifo: DEPTH-entry AXI-Stream FIFO with registered s_in_tready and
// m_out_tvalid, live occupancy count and synchronous flush.
// Optional store-and-forward mode: define AXIS_SKID_FIFO_PKT_MODE_EN.
module axis_skid_fifo #(
  parameter int DWIDTH      = 32,
  parameter int TLAST_WIDTH = 1,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [DWIDTH-1:0]      s_in_tdata,
  input  logic                   s_in_tvalid,
  output logic                   s_in_tready,
  input  logic [TLAST_WIDTH-1:0] s_in_tlast,
  output logic [DWIDTH-1:0]      m_out_tdata,
  output logic                   m_out_tvalid,
  input  logic                   m_out_tready,
  output logic [TLAST_WIDTH-1:0] m_out_tlast,
  output logic [CNT_W-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DWIDTH-1:0]      mem_data [DEPTH];
  logic [TLAST_WIDTH-1:0] mem_last [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push;
  logic                   pop;
  logic [CNT_W-1:0]       count_next;
  logic                   vld_next;

  assign push = s_in_tvalid & s_in_tready;
  assign pop  = m_out_tvalid & m_out_tready;

  // Head of the circular buffer is presented directly on the output
  assign m_out_tdata = mem_data[rd_ptr];
  assign m_out_tlast = mem_last[rd_ptr];

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

`ifdef AXIS_SKID_FIFO_PKT_MODE_EN
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] pkt_cnt_next;
  logic             pkt_in;
  logic             pkt_out;

  assign pkt_in  = push & s_in_tlast[0];
  assign pkt_out = pop & m_out_tlast[0];

  // Number of complete packets (stored tlast beats) after this edge
  always_comb begin
    pkt_cnt_next = pkt_cnt;
    case ({pkt_in, pkt_out})
      2'b10:   pkt_cnt_next = pkt_cnt + CNT_W'(1);
      2'b01:   pkt_cnt_next = pkt_cnt - CNT_W'(1);
      default: pkt_cnt_next = pkt_cnt;
    endcase
  end

  // Packet counter; flush discards all stored packets
  always_ff @(posedge clk) begin
    if (!rst_n || flush) pkt_cnt <= '0;
    else                 pkt_cnt <= pkt_cnt_next;
  end

  // Hold output until a whole packet is stored, unless full: an oversized
  // packet must cut through or the FIFO would deadlock
  assign vld_next = (count_next != '0) &
                    ((pkt_cnt_next != '0) | (count_next == FULL_CNT));
`else
  assign vld_next = (count_next != '0);
`endif

  // Storage writes; a beat accepted during flush is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_data[wr_ptr] <= s_in_tdata;
      mem_last[wr_ptr] <= s_in_tlast;
    end
  end

  // Pointers, count and registered handshake flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      s_in_tready  <= 1'b0;
      m_out_tvalid <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      s_in_tready  <= 1'b1;
      m_out_tvalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      s_in_tready  <= (count_next != FULL_CNT);
      m_out_tvalid <= vld_next;
    end
  end

endmodule

// File: tb/tb_axis_skid_fifo.sv
// Directed self-checking bench for axis_skid_fifo (DEPTH=4, DWIDTH=32).
module tb_axis_skid_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] s_in_tdata;
  logic        s_in_tvalid;
  logic        s_in_tready;
  logic [0:0]  s_in_tlast;
  logic [31:0] m_out_tdata;
  logic        m_out_tvalid;
  logic        m_out_tready;
  logic [0:0]  m_out_tlast;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  axis_skid_fifo #(
    .DWIDTH(32), .TLAST_WIDTH(1), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_in_tdata(s_in_tdata), .s_in_tvalid(s_in_tvalid),
    .s_in_tready(s_in_tready), .s_in_tlast(s_in_tlast),
    .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid),
    .m_out_tready(m_out_tready), .m_out_tlast(m_out_tlast),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_data [$];
  logic        q_last [$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_in_tdata = '0; s_in_tvalid = 1'b0;
    s_in_tlast = '0; m_out_tready = 1'b0;

    // Reset and startup
    repeat (3) step();
    check("rst_tready", {31'd0, s_in_tready}, 32'd0);
    check("rst_tvalid", {31'd0, m_out_tvalid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_tdata", m_out_tdata, 32'd0);
    check("rst_tlast", {31'd0, m_out_tlast}, 32'd0);
    rst_n = 1'b1;
    step();
    check("start_tready", {31'd0, s_in_tready}, 32'd1);
    check("start_tvalid", {31'd0, m_out_tvalid}, 32'd0);

`ifndef AXIS_SKID_FIFO_PKT_MODE_EN
    // Fill to full with downstream stalled
    s_in_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in_tdata = 32'h11 * (i + 1);
      step();
      check("fill_count", {29'd0, count}, i + 1);
      check("fill_tready", {31'd0, s_in_tready}, (i < 3) ? 32'd1 : 32'd0);
      check("fill_tvalid", {31'd0, m_out_tvalid}, 32'd1);
    end
    s_in_tdata = 32'h55;
    step();
    check("full_count", {29'd0, count}, 32'd4);
    check("full_tready", {31'd0, s_in_tready}, 32'd0);
    check("full_head", m_out_tdata, 32'h11);
    // Drain: first pop frees a slot, 0x55 enters on the following edge
    m_out_tready = 1'b1;
    step();
    check("pop1_count", {29'd0, count}, 32'd3);
    check("pop1_tready", {31'd0, s_in_tready}, 32'd1);
    check("pop1_head", m_out_tdata, 32'h22);
    step();
    s_in_tvalid = 1'b0;
    check("pushpop_count", {29'd0, count}, 32'd3);
    check("pushpop_head", m_out_tdata, 32'h33);
    step();
    check("drain_head44", m_out_tdata, 32'h44);
    check("drain_count2", {29'd0, count}, 32'd2);
    step();
    check("drain_head55", m_out_tdata, 32'h55);
    check("drain_count1", {29'd0, count}, 32'd1);
    step();
    check("drain_count0", {29'd0, count}, 32'd0);
    check("drain_tvalid", {31'd0, m_out_tvalid}, 32'd0);

    // Streaming: one beat per cycle, one cycle latency, count stays 1
    s_in_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_in_tdata = i;
      step();
      check("stream_data", m_out_tdata, i);
      check("stream_count", {29'd0, count}, 32'd1);
    end
    s_in_tvalid = 1'b0;
    step();
    check("stream_end_count", {29'd0, count}, 32'd0);
    m_out_tready = 1'b0;

    // Flush with concurrent push and pop discards everything
    s_in_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_in_tdata = 32'hA1 + i;
      step();
    end
    check("preflush_count", {29'd0, count}, 32'd3);
    flush = 1'b1; s_in_tdata = 32'hAA; m_out_tready = 1'b1;
    step();
    flush = 1'b0; s_in_tvalid = 1'b0; m_out_tready = 1'b0;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_tvalid", {31'd0, m_out_tvalid}, 32'd0);
    check("flush_tready", {31'd0, s_in_tready}, 32'd1);
    step();
    check("postflush_tvalid", {31'd0, m_out_tvalid}, 32'd0);
    s_in_tvalid = 1'b1; s_in_tdata = 32'h5A;
    step();
    s_in_tvalid = 1'b0;
    check("postflush_head", m_out_tdata, 32'h5A);
    check("postflush_count", {29'd0, count}, 32'd1);
    m_out_tready = 1'b1;
    step();
    check("postflush_drain", {29'd0, count}, 32'd0);
    m_out_tready = 1'b0;

    // Random handshakes against a queue model
    begin
      int in_cnt = 0;
      int out_cnt = 0;
      logic do_push, do_pop;
      for (int cyc = 0; cyc < 20000 && out_cnt < 1000; cyc++) begin
        s_in_tvalid  = (in_cnt < 1000) && ($urandom_range(0, 1) == 1);
        s_in_tdata   = 32'h1000_0000 + in_cnt;
        s_in_tlast   = ((in_cnt % 7) == 6);
        m_out_tready = ($urandom_range(0, 1) == 1);
        do_push = s_in_tvalid && s_in_tready;
        do_pop  = m_out_tvalid && m_out_tready;
        if (do_pop && q_data.size() > 0) begin
          check("rand_data", m_out_tdata, q_data[0]);
          check("rand_last", {31'd0, m_out_tlast}, {31'd0, q_last[0]});
          void'(q_data.pop_front());
          void'(q_last.pop_front());
          out_cnt++;
        end
        if (do_push) begin
          q_data.push_back(s_in_tdata);
          q_last.push_back(s_in_tlast[0]);
          in_cnt++;
        end
        step();
        check("rand_count", {29'd0, count}, q_data.size());
        check("rand_tready", {31'd0, s_in_tready}, (q_data.size() != 4) ? 32'd1 : 32'd0);
        check("rand_tvalid", {31'd0, m_out_tvalid}, (q_data.size() != 0) ? 32'd1 : 32'd0);
      end
      check("rand_done", out_cnt, 32'd1000);
      s_in_tvalid = 1'b0; s_in_tlast = '0; m_out_tready = 1'b0;
    end
`else
    // Store-and-forward: output held until a tlast beat is stored
    m_out_tready = 1'b1; s_in_tvalid = 1'b1; s_in_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_in_tdata = 32'hB0 + i;
      step();
      check("pkt_wait_tvalid", {31'd0, m_out_tvalid}, 32'd0);
      check("pkt_wait_count", {29'd0, count}, i + 1);
    end
    s_in_tdata = 32'hB3; s_in_tlast = 1'b1;
    step();
    s_in_tvalid = 1'b0; s_in_tlast = 1'b0;
    check("pkt_rdy_tvalid", {31'd0, m_out_tvalid}, 32'd1);
    check("pkt_rdy_count", {29'd0, count}, 32'd4);
    check("pkt_rdy_head", m_out_tdata, 32'hB0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("pkt_drain_count", {29'd0, count}, 3 - i);
      check("pkt_drain_tvalid", {31'd0, m_out_tvalid}, (i < 3) ? 32'd1 : 32'd0);
    end
    // Oversized packet: valid only once the FIFO fills
    m_out_tready = 1'b0; s_in_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in_tdata = 32'hC0 + i;
      step();
      check("pkt_long_tvalid", {31'd0, m_out_tvalid}, (i == 3) ? 32'd1 : 32'd0);
    end
    s_in_tvalid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("pkt_flush_count", {29'd0, count}, 32'd0);
    check("pkt_flush_tvalid", {31'd0, m_out_tvalid}, 32'd0);
`endif

    // Reset mid-operation discards contents
    s_in_tvalid = 1'b1; s_in_tlast = 1'b0;
    s_in_tdata = 32'h77; step();
    s_in_tdata = 32'h78; step();
    s_in_tvalid = 1'b0;
    check("mid_pre_count", {29'd0, count}, 32'd2);
    rst_n = 1'b0;
    step();
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_tready", {31'd0, s_in_tready}, 32'd0);
    check("mid_rst_tvalid", {31'd0, m_out_tvalid}, 32'd0);
    check("mid_rst_tdata", m_out_tdata, 32'd0);
    rst_n = 1'b1;
    step();
    check("mid_rel_tready", {31'd0, s_in_tready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_skid_fifo.md
Name: axis_skid_fifo

Overview:
- Parametrised successor to the 2-entry AXI-Stream register slice.
- Stores DEPTH beats with full throughput and registered s_in_tready and m_out_tvalid; exposes live occupancy; supports a synchronous flush.
- Sits between data-route stages (PE array ↔ DMA) where elastic buffering beyond two beats is needed.

Parameters:
- DWIDTH, 32, tdata width in bits.
- TLAST_WIDTH, 1, tlast width in bits; bit 0 marks end of packet.
- DEPTH, 4, number of beat entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all stored beats.
- s_in_tdata  in  DWIDTH  upstream data.
- s_in_tvalid  in  1  upstream valid.
- s_in_tready  out  1  registered ready.
- s_in_tlast  in  TLAST_WIDTH  upstream last.
- m_out_tdata  out  DWIDTH  downstream data = storage[rd_ptr].
- m_out_tvalid  out  1  registered valid.
- m_out_tready  in  1  downstream ready.
- m_out_tlast  out  TLAST_WIDTH  downstream last = tlast storage[rd_ptr].
- count  out  CNT_W  registered number of stored beats, 0..DEPTH.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: s_in_tready=0, m_out_tvalid=0, count=0, wr_ptr=rd_ptr=0, all storage 0 (so m_out_tdata=0, m_out_tlast=0).
- First edge with rst_n=1: s_in_tready→1.
- Reset mid-operation discards all contents; outputs take reset values on the next edge.
- Definitions: push = s_in_tvalid & s_in_tready; pop = m_out_tvalid & m_out_tready.
- Storage:
  - Circular buffer; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1→0 naturally.
  - push writes s_in_tdata/s_in_tlast at wr_ptr, then wr_ptr+1.
  - pop advances rd_ptr+1.
- count_next:
  - count+1 on push only.
  - count-1 on pop only.
  - count unchanged on both or neither.
- Registered flags, computed from count_next:
  - s_in_tready ← (count_next != DEPTH).
  - m_out_tvalid ← (count_next != 0); see packet-mode override under Optional Feature.
- Latency and throughput:
  - Beat pushed at edge N into an empty FIFO → m_out_tvalid=1 with that data after edge N.
  - One beat per cycle sustained in both directions when both sides are always ready.
- Boundary conditions:
  - Full (count=DEPTH): s_in_tready=0, so no push. A pop that cycle gives count=DEPTH-1 and s_in_tready=1 after the edge.
  - Empty: m_out_tvalid=0, so no pop. Simultaneous push → count=1.
  - Simultaneous push and pop at any 0<count<DEPTH: count unchanged, order preserved.
- Ordering: strictly FIFO; m_out_tdata/m_out_tlast change only on pop or on a push into an empty buffer.
- Upstream rule: upstream data and tlast held stable while s_in_tvalid=1 and s_in_tready=0; the block does not check this.
- Flush (priority over push/pop, below rst_n):
  - At an edge with flush=1: pointers and count→0, storage contents left but unreachable.
  - Any push/pop handshake in that cycle is discarded: the beat is consumed, never delivered.
  - After the edge: m_out_tvalid=0, s_in_tready=1.
- No state machine beyond the count; states are EMPTY (count=0), PARTIAL, FULL (count=DEPTH), fully implied by count.

Optional Feature:
- Macro: AXIS_SKID_FIFO_PKT_MODE_EN.
- Defined:
  - Store-and-forward mode. An internal pkt_cnt (CNT_W bits) counts stored beats with tlast[0]=1: +1 on push with s_in_tlast[0], -1 on pop with m_out_tlast[0]. pkt_cnt is cleared by reset and by flush.
  - m_out_tvalid ← (count_next != 0) & ((pkt_cnt_next != 0) | (count_next == DEPTH)).
  - The DEPTH term is a deadlock-avoidance fallback: packets longer than DEPTH stream through cut-through.
- Undefined: m_out_tvalid ← (count_next != 0); no pkt_cnt logic is synthesised.

Test Plan:
- Reset/startup: rst_n=0 for 3 cycles, then 1 → s_in_tready 0→1 one edge after release; m_out_tvalid=0, count=0, m_out_tdata=0.
- Fill/drain: DEPTH=4, m_out_tready=0, push 0x11,0x22,0x33,0x44,0x55 continuously → 0x55 stalls; s_in_tready=0 after 4th push, count=4; then m_out_tready=1 → out 0x11..0x55 in order, 0x55 accepted the cycle after first pop.
- Streaming: both sides always ready, push 0..99 → 100 beats out in order, one per cycle, one cycle latency, count stays 1.
- Random backpressure: random tvalid/tready at 50%, 1000 beats with tlast every 7th → scoreboard match of data and tlast, count matches model every cycle, wrap-around exercised.
- Flush: count=3, assert flush one cycle with push of 0xAA concurrent → next cycle count=0, m_out_tvalid=0, s_in_tready=1; 0xAA never appears.
- Packet mode (macro defined, DEPTH=4): push 3 beats without tlast → m_out_tvalid stays 0; 4th beat with tlast=1 → m_out_tvalid=1 after edge. Separately, 6-beat packet → m_out_tvalid=1 once count=4 (fallback).
